// File: rtl/param_control_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared definitions for the parametrised control sequencer: control-word
// width and bit positions, the packed control-word struct, opcode encodings
// and the fixed fetch-phase words.
// ---------------------------------------------------------------------------
package ctrl_seq_pkg;

   localparam int unsigned CW_W = 18;
   localparam int unsigned OP_W = 4;

   // Control-word bit positions, MSB first
   localparam int unsigned CW_CP    = 17;
   localparam int unsigned CW_EP    = 16;
   localparam int unsigned CW_LMP   = 15;
   localparam int unsigned CW_LMI   = 14;
   localparam int unsigned CW_CEI   = 13;
   localparam int unsigned CW_CEA   = 12;
   localparam int unsigned CW_LI    = 11;
   localparam int unsigned CW_EI    = 10;
   localparam int unsigned CW_LARAM = 9;
   localparam int unsigned CW_LAB   = 8;
   localparam int unsigned CW_EATMP = 7;
   localparam int unsigned CW_SU    = 6;
   localparam int unsigned CW_EU    = 5;
   localparam int unsigned CW_LBTMP = 4;
   localparam int unsigned CW_EBA   = 3;
   localparam int unsigned CW_LO    = 2;
   localparam int unsigned CW_LTMPA = 1;
   localparam int unsigned CW_ETMPB = 0;

   typedef struct packed {
      logic Cp;
      logic Ep;
      logic Lmp;
      logic Lmi;
      logic Cei;
      logic Cea;
      logic Li;
      logic Ei;
      logic LaRam;
      logic Lab;
      logic Eatmp;
      logic Su;
      logic Eu;
      logic Lbtmp;
      logic Eba;
      logic Lo;
      logic Ltmpa;
      logic Etmpb;
   } cw_t;

   localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
   localparam logic [OP_W-1:0] OP_XCHG = 4'b0011;
   localparam logic [OP_W-1:0] OP_LDA  = 4'b0111;
   localparam logic [OP_W-1:0] OP_HLT  = 4'b1110;
   localparam logic [OP_W-1:0] OP_OUT  = 4'b1111;

   // Fetch words: T1 Ep|Lmp, T2 Cp, T3 Cei|Li
   localparam cw_t CW_FETCH_T1 = cw_t'(18'h18000);
   localparam cw_t CW_FETCH_T2 = cw_t'(18'h20000);
   localparam cw_t CW_FETCH_T3 = cw_t'(18'h02800);
   localparam cw_t CW_NONE     = cw_t'('0);

   // A word that touches RAM is the only kind that can be stretched by a
   // wait state.
   function automatic logic cw_mem_access(input cw_t w);
      return w.Cei | w.Cea;
   endfunction

endpackage

// File: rtl/param_control_sequencer_t_ring_counter.sv
// ---------------------------------------------------------------------------
// t_ring_counter
// One-hot T-state ring. Updates on the falling edge; async active-low reset
// to bit 0 (T1). Controls in priority order: hold, restart (to T1), advance.
// The next-state value is exported so the parent can decode registered
// outputs from it.
//   clk        in   clock (falling-edge active)
//   rst_n      in   async active-low reset
//   hold_i     in   keep current state
//   restart_i  in   go to T1
//   advance_i  in   rotate to next T-state (wraps to T1)
//   t_q_o      out  current one-hot state
//   t_d_o      out  next one-hot state
// ---------------------------------------------------------------------------
module t_ring_counter #(
   parameter int unsigned NUM_T = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold_i,
   input  logic             restart_i,
   input  logic             advance_i,
   output logic [NUM_T-1:0] t_q_o,
   output logic [NUM_T-1:0] t_d_o
);

   logic [NUM_T-1:0] t_q;
   logic [NUM_T-1:0] t_d;

   always_comb begin
      t_d = t_q;
      if (hold_i) begin
         t_d = t_q;
      end else if (restart_i) begin
         t_d    = '0;
         t_d[0] = 1'b1;
      end else if (advance_i) begin
         t_d = {t_q[NUM_T-2:0], t_q[NUM_T-1]};
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q <= NUM_T'(1);
      end else begin
         t_q <= t_d;
      end
   end

   assign t_q_o = t_q;
   assign t_d_o = t_d;

endmodule

// File: rtl/param_control_sequencer.sv
// ---------------------------------------------------------------------------
// param_control_sequencer
// One-hot T-state sequencer with instruction decode producing the packed
// control word. Variable-length instructions, RAM wait-state stall, latched
// opcode, HLT with run restart and an instruction-done strobe. All state
// and outputs change on the falling edge of clk.
//   clk         in   system clock (falling-edge active)
//   reset       in   async active-low reset
//   ir_opcode   in   opcode from IR
//   mem_ready   in   RAM ready; 0 stalls states driving Cei or Cea
//   run         in   restart request, honoured only while halted
//   ctrl_word   out  registered control word
//   t_state     out  one-hot current T-state (bit 0 = T1)
//   instr_done  out  high in the final T-state of an instruction
//   halted      out  high while stopped on HLT
// ---------------------------------------------------------------------------
module param_control_sequencer #(
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned NUM_T    = 6,
   parameter int unsigned CW_W     = ctrl_seq_pkg::CW_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] ir_opcode,
   input  logic                mem_ready,
   input  logic                run,
   output logic [CW_W-1:0]     ctrl_word,
   output logic [NUM_T-1:0]    t_state,
   output logic                instr_done,
   output logic                halted
);

   import ctrl_seq_pkg::*;

   if (NUM_T < 6) begin : g_bad_num_t
      $error("param_control_sequencer: NUM_T must be at least 6");
   end
   if (CW_W != ctrl_seq_pkg::CW_W) begin : g_bad_cw_w
      $error("param_control_sequencer: CW_W is fixed by ctrl_seq_pkg");
   end

   // Last T-state index (1-based) of each opcode; undefined opcodes end at T3.
   function automatic int unsigned op_len(input logic [OPCODE_W-1:0] op);
      if (op == OPCODE_W'(OP_LDA))  return 5;
      if (op == OPCODE_W'(OP_XCHG)) return 6;
      if (op == OPCODE_W'(OP_ADD) || op == OPCODE_W'(OP_SUB) ||
          op == OPCODE_W'(OP_OUT) || op == OPCODE_W'(OP_HLT)) return 4;
      return 3;
   endfunction

   // Execute-phase word for T4 and beyond; anything unlisted is all-zero.
   function automatic cw_t exec_word(input int unsigned idx,
                                     input logic [OPCODE_W-1:0] op);
      cw_t w;
      w = CW_NONE;
      if (idx == 4) begin
         if (op == OPCODE_W'(OP_LDA)) begin
            w.Lmi = 1'b1;
            w.Ei  = 1'b1;
         end else if (op == OPCODE_W'(OP_XCHG)) begin
            w.Eatmp = 1'b1;
            w.Ltmpa = 1'b1;
         end else if (op == OPCODE_W'(OP_ADD)) begin
            w.Eu = 1'b1;
         end else if (op == OPCODE_W'(OP_SUB)) begin
            w.Su = 1'b1;
            w.Eu = 1'b1;
         end else if (op == OPCODE_W'(OP_OUT)) begin
            w.Lo = 1'b1;
         end
      end else if (idx == 5) begin
         if (op == OPCODE_W'(OP_LDA)) begin
            w.Cea   = 1'b1;
            w.LaRam = 1'b1;
         end else if (op == OPCODE_W'(OP_XCHG)) begin
            w.Lab = 1'b1;
            w.Eba = 1'b1;
         end
      end else if (idx == 6) begin
         if (op == OPCODE_W'(OP_XCHG)) begin
            w.Lbtmp = 1'b1;
            w.Etmpb = 1'b1;
         end
      end
      return w;
   endfunction

   logic [NUM_T-1:0]    t_q;
   logic [NUM_T-1:0]    t_d;
   logic [OPCODE_W-1:0] op_q;
   logic [OPCODE_W-1:0] op_d;
   cw_t                 cw_q;
   cw_t                 cw_d;
   logic                done_q;
   logic                done_d;
   logic                halted_q;
   logic                halted_d;
   logic                stall;
   logic                hold;
   logic                restart;
   logic                halt_enter;
   int unsigned         idx_d;

   // The stall is judged on the word currently presented, so it is known
   // without waiting for the next decode.
   assign stall   = !mem_ready && cw_mem_access(cw_q);
   assign hold    = stall || (halted_q && !run);
   assign restart = (halted_q && run) || done_q;

   t_ring_counter #(
      .NUM_T(NUM_T)
   ) u_ring (
      .clk       (clk),
      .rst_n     (reset),
      .hold_i    (hold),
      .restart_i (restart),
      .advance_i (1'b1),
      .t_q_o     (t_q),
      .t_d_o     (t_d)
   );

   always_comb begin
      idx_d = 0;
      for (int unsigned i = 0; i < NUM_T; i++) begin
         if (t_d[i]) idx_d = i + 1;
      end
   end

   // Opcode is captured only on the T3 -> T4 step.
   assign op_d = (t_q[2] && t_d[3]) ? ir_opcode : op_q;

   // Outputs are decoded from the next state and registered alongside it.
   // The T3 end-of-instruction decision has to come from ir_opcode directly,
   // since the latch has not been loaded yet when entering T3.
   always_comb begin
      cw_d       = cw_q;
      done_d     = done_q;
      halted_d   = halted_q;
      halt_enter = 1'b0;
      if (!hold) begin
         done_d   = 1'b0;
         halted_d = 1'b0;
         case (idx_d)
            1: cw_d = CW_FETCH_T1;
            2: cw_d = CW_FETCH_T2;
            3: begin
               cw_d   = CW_FETCH_T3;
               done_d = (op_len(ir_opcode) == 3);
            end
            default: begin
               halt_enter = (idx_d == 4) && (op_d == OPCODE_W'(OP_HLT));
               cw_d       = exec_word(idx_d, op_d);
               done_d     = !halt_enter && (idx_d >= op_len(op_d));
               halted_d   = halt_enter;
            end
         endcase
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         cw_q     <= CW_FETCH_T1;
         op_q     <= OPCODE_W'(OP_NOP);
         done_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         cw_q     <= cw_d;
         op_q     <= op_d;
         done_q   <= done_d;
         halted_q <= halted_d;
      end
   end

   assign ctrl_word  = cw_q;
   assign t_state    = t_q;
   assign instr_done = done_q && !stall;
   assign halted     = halted_q;

endmodule

// File: tb/tb_param_control_sequencer.sv
module tb_param_control_sequencer;

   logic       clk;
   logic       reset;
   logic [3:0] ir_opcode;
   logic       mem_ready;
   logic       run;
   logic [17:0] ctrl_word;
   logic [5:0]  t_state;
   logic        instr_done;
   logic        halted;

   int unsigned total;
   int unsigned failed;

   // Hand-derived control words
   localparam logic [17:0] W_T1    = 18'h18000; // Ep|Lmp
   localparam logic [17:0] W_T2    = 18'h20000; // Cp
   localparam logic [17:0] W_T3    = 18'h02800; // Cei|Li
   localparam logic [17:0] W_LDA4  = 18'h04400; // Lmi|Ei
   localparam logic [17:0] W_LDA5  = 18'h01200; // Cea|LaRam
   localparam logic [17:0] W_XCH4  = 18'h00082; // Eatmp|Ltmpa
   localparam logic [17:0] W_XCH5  = 18'h00108; // Lab|Eba
   localparam logic [17:0] W_XCH6  = 18'h00011; // Lbtmp|Etmpb
   localparam logic [17:0] W_ADD4  = 18'h00020; // Eu
   localparam logic [17:0] W_SUB4  = 18'h00060; // Su|Eu
   localparam logic [17:0] W_OUT4  = 18'h00004; // Lo

   param_control_sequencer #(
      .OPCODE_W(4),
      .NUM_T   (6),
      .CW_W    (18)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ir_opcode  (ir_opcode),
      .mem_ready  (mem_ready),
      .run        (run),
      .ctrl_word  (ctrl_word),
      .t_state    (t_state),
      .instr_done (instr_done),
      .halted     (halted)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (total=%0d)", total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [5:0] t, input logic [17:0] cw,
                            input logic d, input logic h);
      check({tag, ".t_state"},    32'(t_state),    32'(t));
      check({tag, ".ctrl_word"},  32'(ctrl_word),  32'(cw));
      check({tag, ".instr_done"}, 32'(instr_done), 32'(d));
      check({tag, ".halted"},     32'(halted),     32'(h));
   endtask

   // Advance to just after the next state-update edge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      failed    = 0;
      reset     = 1'b1;
      ir_opcode = 4'b0000;
      mem_ready = 1'b1;
      run       = 1'b0;

      // Reset
      #1 reset = 1'b0;
      #1 expect_st("reset", 6'b000001, W_T1, 1'b0, 1'b0);
      #1 reset = 1'b1;

      // NOP stream: 3-edge period, done in T3
      step(); expect_st("nop0.T2", 6'b000010, W_T2, 1'b0, 1'b0);
      step(); expect_st("nop0.T3", 6'b000100, W_T3, 1'b1, 1'b0);
      step(); expect_st("nop0.T1", 6'b000001, W_T1, 1'b0, 1'b0);
      step(); expect_st("nop1.T2", 6'b000010, W_T2, 1'b0, 1'b0);
      step(); expect_st("nop1.T3", 6'b000100, W_T3, 1'b1, 1'b0);
      step(); expect_st("nop1.T1", 6'b000001, W_T1, 1'b0, 1'b0);

      // LDA
      ir_opcode = 4'b0111;
      step(); expect_st("lda.T2", 6'b000010, W_T2,   1'b0, 1'b0);
      step(); expect_st("lda.T3", 6'b000100, W_T3,   1'b0, 1'b0);
      step(); expect_st("lda.T4", 6'b001000, W_LDA4, 1'b0, 1'b0);
      step(); expect_st("lda.T5", 6'b010000, W_LDA5, 1'b1, 1'b0);
      step(); expect_st("lda.T1", 6'b000001, W_T1,   1'b0, 1'b0);

      // XCHG with opcode changed during T5
      ir_opcode = 4'b0011;
      step(); expect_st("xchg.T2", 6'b000010, W_T2,   1'b0, 1'b0);
      step(); expect_st("xchg.T3", 6'b000100, W_T3,   1'b0, 1'b0);
      step(); expect_st("xchg.T4", 6'b001000, W_XCH4, 1'b0, 1'b0);
      step(); expect_st("xchg.T5", 6'b010000, W_XCH5, 1'b0, 1'b0);
      ir_opcode = 4'b0001;
      step(); expect_st("xchg.T6", 6'b100000, W_XCH6, 1'b1, 1'b0);
      step(); expect_st("xchg.T1", 6'b000001, W_T1,   1'b0, 1'b0);

      // ADD (opcode still 0001)
      step(); expect_st("add.T2", 6'b000010, W_T2,   1'b0, 1'b0);
      step(); expect_st("add.T3", 6'b000100, W_T3,   1'b0, 1'b0);
      step(); expect_st("add.T4", 6'b001000, W_ADD4, 1'b1, 1'b0);
      step(); expect_st("add.T1", 6'b000001, W_T1,   1'b0, 1'b0);

      // SUB
      ir_opcode = 4'b0010;
      step(); step();
      step(); expect_st("sub.T4", 6'b001000, W_SUB4, 1'b1, 1'b0);
      step(); expect_st("sub.T1", 6'b000001, W_T1,   1'b0, 1'b0);

      // OUT
      ir_opcode = 4'b1111;
      step(); step();
      step(); expect_st("out.T4", 6'b001000, W_OUT4, 1'b1, 1'b0);
      step(); expect_st("out.T1", 6'b000001, W_T1,   1'b0, 1'b0);

      // LDA with two wait states in T5; mem_ready low in T4 is ignored
      ir_opcode = 4'b0111;
      step(); expect_st("ldaw.T2", 6'b000010, W_T2,   1'b0, 1'b0);
      step(); expect_st("ldaw.T3", 6'b000100, W_T3,   1'b0, 1'b0);
      step(); expect_st("ldaw.T4", 6'b001000, W_LDA4, 1'b0, 1'b0);
      mem_ready = 1'b0;
      step(); expect_st("ldaw.T5a", 6'b010000, W_LDA5, 1'b0, 1'b0);
      step(); expect_st("ldaw.T5b", 6'b010000, W_LDA5, 1'b0, 1'b0);
      mem_ready = 1'b1;
      #1 expect_st("ldaw.T5c", 6'b010000, W_LDA5, 1'b1, 1'b0);
      step(); expect_st("ldaw.T1", 6'b000001, W_T1, 1'b0, 1'b0);

      // HLT, frozen for 10 cycles, then run restart
      ir_opcode = 4'b1110;
      step(); expect_st("hlt.T2", 6'b000010, W_T2, 1'b0, 1'b0);
      step(); expect_st("hlt.T3", 6'b000100, W_T3, 1'b0, 1'b0);
      step(); expect_st("hlt.T4", 6'b001000, 18'h0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(); expect_st($sformatf("hlt.hold%0d", i), 6'b001000, 18'h0, 1'b0, 1'b1);
      end
      run = 1'b1;
      ir_opcode = 4'b0000;
      step(); expect_st("hlt.run", 6'b000001, W_T1, 1'b0, 1'b0);
      // run held high while not halted must be ignored
      step(); expect_st("run.ign", 6'b000010, W_T2, 1'b0, 1'b0);
      run = 1'b0;
      step(); expect_st("post.T3", 6'b000100, W_T3, 1'b1, 1'b0);
      step(); expect_st("post.T1", 6'b000001, W_T1, 1'b0, 1'b0);

      // Reset mid XCHG T5, between edges
      ir_opcode = 4'b0011;
      step(); step(); step();
      step(); expect_st("xrst.T5", 6'b010000, W_XCH5, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 expect_st("xrst.async", 6'b000001, W_T1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      step(); expect_st("xrst.T2", 6'b000010, W_T2,   1'b0, 1'b0);
      step(); expect_st("xrst.T3", 6'b000100, W_T3,   1'b0, 1'b0);
      step(); expect_st("xrst.T4", 6'b001000, W_XCH4, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", total - failed, total);
      $finish;
   end

endmodule
